// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - decode-to-execute register producing the ALU operand/opcode bundle
// Decodes a MIPS instruction word into op code, operands and destination, held behind valid/ready.

module alu_issue_stage #(
    parameter int         WIDTH            = 32,
    parameter logic [5:0] REGIMM_BGEZ_CODE = 6'h3E
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w_flush_1,
    input  logic             w_in_valid_1,
    output logic             w_in_ready_1,
    input  logic [31:0]      w_instr_32,
    input  logic [WIDTH-1:0] w_rs_data_x,
    input  logic [WIDTH-1:0] w_rt_data_x,
    output logic             w_out_valid_1,
    input  logic             w_out_ready_1,
    output logic [5:0]       w_op_code_6,
    output logic [WIDTH-1:0] w_input1_x,
    output logic [WIDTH-1:0] w_input2_x,
    output logic [4:0]       w_dest_reg_5,
    output logic             w_reg_write_1,
    output logic             w_illegal_1
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2B;

    logic [5:0]  op;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign op    = w_instr_32[31:26];
    assign rt    = w_instr_32[20:16];
    assign rd    = w_instr_32[15:11];
    assign shamt = w_instr_32[10:6];
    assign funct = w_instr_32[5:0];
    assign imm   = w_instr_32[15:0];

    // The rs index is never needed here: its value arrives already read as w_rs_data_x.
    logic unused_rs_field;
    assign unused_rs_field = ^w_instr_32[25:21];

    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] imm_zext;
    logic [WIDTH-1:0] imm_upper;

    assign imm_sext  = WIDTH'($signed(imm));
    assign imm_zext  = WIDTH'(imm);
    assign imm_upper = WIDTH'({imm, 16'h0000});

    logic [5:0]       d_op_code;
    logic [WIDTH-1:0] d_input1;
    logic [WIDTH-1:0] d_input2;
    logic [4:0]       d_dest;
    logic             d_reg_write;
    logic             d_illegal;

    always_comb begin
        d_op_code   = op;
        d_input1    = '0;
        d_input2    = '0;
        d_dest      = 5'd0;
        d_reg_write = 1'b0;
        d_illegal   = 1'b0;
        case (op)
            OP_SPECIAL: begin
                d_op_code   = funct;
                d_dest      = rd;
                d_reg_write = 1'b1;
                case (funct)
                    6'h00, 6'h02, 6'h03: begin
                        d_input1 = w_rt_data_x;
                        d_input2 = WIDTH'(shamt);
                    end
                    6'h04, 6'h06, 6'h07: begin
                        d_input1 = w_rt_data_x;
                        d_input2 = WIDTH'(w_rs_data_x[4:0]);
                    end
                    6'h18, 6'h19, 6'h1A, 6'h1B,
                    6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B: begin
                        d_input1 = w_rs_data_x;
                        d_input2 = w_rt_data_x;
                    end
                    default: d_illegal = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                d_input1 = w_rs_data_x;
                if (rt == 5'd0) begin
                    d_op_code = 6'h01;
                end else if (rt == 5'd1) begin
                    d_op_code = REGIMM_BGEZ_CODE;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            OP_BEQ, OP_BNE: begin
                d_input1 = w_rs_data_x;
                d_input2 = w_rt_data_x;
            end
            OP_BLEZ, OP_BGTZ: begin
                d_input1 = w_rs_data_x;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_LB, OP_LW, OP_LBU: begin
                d_input1    = w_rs_data_x;
                d_input2    = imm_sext;
                d_dest      = rt;
                d_reg_write = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                d_input1    = w_rs_data_x;
                d_input2    = imm_zext;
                d_dest      = rt;
                d_reg_write = 1'b1;
            end
            OP_LUI: begin
                d_input2    = imm_upper;
                d_dest      = rt;
                d_reg_write = 1'b1;
            end
            OP_SB, OP_SW: begin
                d_input1 = w_rs_data_x;
                d_input2 = imm_sext;
            end
            default: d_illegal = 1'b1;
        endcase

        // Illegal encodings still travel down the pipe, but must never touch state.
        if (d_illegal) begin
            d_input1    = '0;
            d_input2    = '0;
            d_dest      = 5'd0;
            d_reg_write = 1'b0;
        end
        if (d_dest == 5'd0) begin
            d_reg_write = 1'b0;
        end
    end

    logic capture;

    assign w_in_ready_1 = !w_flush_1 && (!w_out_valid_1 || w_out_ready_1);
    assign capture      = w_in_valid_1 && w_in_ready_1;

    always_ff @(posedge clk) begin
        if (reset) begin
            w_out_valid_1 <= 1'b0;
            w_op_code_6   <= 6'd0;
            w_input1_x    <= '0;
            w_input2_x    <= '0;
            w_dest_reg_5  <= 5'd0;
            w_reg_write_1 <= 1'b0;
            w_illegal_1   <= 1'b0;
        end else if (w_flush_1) begin
            w_out_valid_1 <= 1'b0;
        end else if (capture) begin
            w_out_valid_1 <= 1'b1;
            w_op_code_6   <= d_op_code;
            w_input1_x    <= d_input1;
            w_input2_x    <= d_input2;
            w_dest_reg_5  <= d_dest;
            w_reg_write_1 <= d_reg_write;
            w_illegal_1   <= d_illegal;
        end else if (w_out_valid_1 && w_out_ready_1) begin
            w_out_valid_1 <= 1'b0;
        end
    end

endmodule
